// File: rtl/vc_fifo_pkg.sv
// Shared definitions for the virtual-channel input buffer.
// Width helpers are reused by the router arbiter and the credit counter.
package vc_fifo_pkg;

    function automatic int vc_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int d);
        return $clog2(d + 1);
    endfunction

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_NUM_VC = 4;
    localparam int VC_W       = vc_w(DEF_NUM_VC);
    localparam int CNT_W      = cnt_w(DEF_DEPTH);

    typedef logic [VC_W-1:0] vc_idx_t;

    function automatic logic [CNT_W-1:0] cnt_unpack(
        input logic [DEF_NUM_VC*CNT_W-1:0] vec,
        input vc_idx_t                     idx
    );
        return vec[int'(idx)*CNT_W +: CNT_W];
    endfunction

endpackage

// File: rtl/vc_fifo_chan.sv
// Single virtual-channel circular buffer with show-ahead head.
// Callers only assert pop_en_i when the channel is non-empty.
module vc_fifo_chan
    import vc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CW        = cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_en_i,
    input  logic                  pop_en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [CW-1:0]         count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    // DEPTH need not be a power of two, so wrap explicitly.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en_i)
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop_en_i)
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        unique case ({push_en_i, pop_en_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en_i && !rst)
            mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/vc_fifo.sv
// Multi-VC router input buffer: one push and one pop port steered by VC index.
// Sticky overflow/underflow record any rejected request.
module vc_fifo
    import vc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int NUM_VC     = 4,
    parameter int AF_MARGIN  = 1,
    localparam int VW        = vc_w(NUM_VC),
    localparam int CW        = cnt_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [VW-1:0]          push_vc,
    input  logic [DATA_WIDTH-1:0]  push_data,
    input  logic                   pop,
    input  logic [VW-1:0]          pop_vc,
    output logic [DATA_WIDTH-1:0]  pop_data,
    output logic [NUM_VC-1:0]      full,
    output logic [NUM_VC-1:0]      empty,
    output logic [NUM_VC-1:0]      almost_full,
    output logic [NUM_VC*CW-1:0]   count,
    output logic                   overflow,
    output logic                   underflow
);

    logic [DATA_WIDTH-1:0] head [NUM_VC];
    logic [CW-1:0]         cnt  [NUM_VC];
    logic [NUM_VC-1:0]     push_en, pop_en;
    logic                  push_hit, pop_hit;
    logic                  tgt_full, src_empty;
    logic                  push_ok, pop_ok;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    // Out-of-range VC indices never hit, so they are rejected.
    always_comb begin
        push_hit  = 1'b0;
        pop_hit   = 1'b0;
        tgt_full  = 1'b0;
        src_empty = 1'b1;
        for (int i = 0; i < NUM_VC; i++) begin
            if (push_vc == VW'(i)) begin
                push_hit = 1'b1;
                tgt_full = full[i];
            end
            if (pop_vc == VW'(i)) begin
                pop_hit   = 1'b1;
                src_empty = empty[i];
            end
        end
        pop_ok  = pop && pop_hit && !src_empty;
        push_ok = push && push_hit &&
                  (!tgt_full || (pop && pop_vc == push_vc));
        for (int i = 0; i < NUM_VC; i++) begin
            push_en[i] = push_ok && (push_vc == VW'(i));
            pop_en[i]  = pop_ok && (pop_vc == VW'(i));
        end
    end

    always_comb begin
        pop_data = '0;
        for (int i = 0; i < NUM_VC; i++)
            if (pop_vc == VW'(i) && !empty[i])
                pop_data = head[i];
    end

    for (genvar g = 0; g < NUM_VC; g++) begin : g_chan
        vc_fifo_chan #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .push_en_i (push_en[g]),
            .pop_en_i  (pop_en[g]),
            .data_i    (push_data),
            .head_o    (head[g]),
            .count_o   (cnt[g]),
            .full_o    (full[g]),
            .empty_o   (empty[g])
        );
        assign count[g*CW +: CW] = cnt[g];
        assign almost_full[g]    = (cnt[g] >= CW'(DEPTH - AF_MARGIN));
    end

    assign overflow_d  = overflow_q  | (push && !push_ok);
    assign underflow_d = underflow_q | (pop && !pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_vc_fifo.sv
// Self-checking bench for vc_fifo against a queue-per-VC reference model.
// Directed scenarios first, then a randomized push/pop soak.
module tb_vc_fifo;
    import vc_fifo_pkg::*;

    localparam int DW  = 32;
    localparam int D   = 4;
    localparam int NV  = 4;
    localparam int AFM = 1;
    localparam int VW  = 2;
    localparam int CW  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           push, pop;
    logic [VW-1:0]  push_vc, pop_vc;
    logic [DW-1:0]  push_data, pop_data;
    logic [NV-1:0]  full, empty, almost_full;
    logic [NV*CW-1:0] count;
    logic           overflow, underflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq [NV][$];
    logic          m_ovf, m_unf;

    always #5 clk = ~clk;

    vc_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (D),
        .NUM_VC     (NV),
        .AF_MARGIN  (AFM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_vc     (push_vc),
        .push_data   (push_data),
        .pop         (pop),
        .pop_vc      (pop_vc),
        .pop_data    (pop_data),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    function automatic logic [NV*CW-1:0] m_count();
        logic [NV*CW-1:0] r = '0;
        for (int v = 0; v < NV; v++) r[v*CW +: CW] = CW'(mq[v].size());
        return r;
    endfunction

    function automatic logic [NV-1:0] m_empty();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = (mq[v].size() == 0);
        return r;
    endfunction

    function automatic logic [NV-1:0] m_full();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = (mq[v].size() == D);
        return r;
    endfunction

    function automatic logic [NV-1:0] m_af();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = (mq[v].size() >= D - AFM);
        return r;
    endfunction

    function automatic logic [DW-1:0] m_head(input int v);
        return (mq[v].size() > 0) ? mq[v][0] : '0;
    endfunction

    function automatic logic [3*NV+NV*CW+1:0] m_status();
        return {m_count(), m_empty(), m_full(), m_af(), m_ovf, m_unf};
    endfunction

    function automatic logic [3*NV+NV*CW+1:0] dut_status();
        return {count, empty, full, almost_full, overflow, underflow};
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) mq[v].delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One clock of stimulus; obs is pop_data sampled before the edge.
    task automatic cycle(input bit pu, input int pvc, input logic [DW-1:0] d,
                         input bit po, input int ovc, output logic [DW-1:0] obs);
        bit pop_acc, push_acc;
        push = pu; push_vc = VW'(pvc); push_data = d;
        pop = po;  pop_vc = VW'(ovc);
        #1 obs = pop_data;
        @(posedge clk);
        pop_acc  = po && mq[ovc].size() > 0;
        push_acc = pu && (mq[pvc].size() < D || (po && ovc == pvc));
        if (pop_acc) void'(mq[ovc].pop_front());
        if (push_acc) mq[pvc].push_back(d);
        if (pu && !push_acc) m_ovf = 1'b1;
        if (po && !pop_acc) m_unf = 1'b1;
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (count !== '0) begin
            errors++; $display("FAIL reset_count got %h exp 0", count);
        end
        checks++;
        if (empty !== 4'hF || full !== 4'h0 || almost_full !== 4'h0) begin
            errors++;
            $display("FAIL reset_flags got e=%h f=%h af=%h exp e=f f=0 af=0",
                     empty, full, almost_full);
        end
        checks++;
        if ({overflow, underflow} !== 2'b00) begin
            errors++; $display("FAIL reset_sticky got %b exp 00", {overflow, underflow});
        end
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] obs;
        for (int i = 0; i < D; i++) begin
            cycle(1, 2, DW'(32'hA0 + i), 0, 0, obs);
            checks++;
            if (cnt_unpack(count, 2'd2) !== CW'(i + 1) || almost_full[2] !== (i >= 2)
                || full[2] !== (i == 3) || empty !== 4'b1011) begin
                errors++;
                $display("FAIL fill_vc2 step %0d got cnt=%0d af=%b f=%b e=%b exp cnt=%0d",
                         i, cnt_unpack(count, 2'd2), almost_full[2], full[2], empty, i + 1);
            end
        end
        for (int i = 0; i < D; i++) begin
            cycle(0, 0, 0, 1, 2, obs);
            checks++;
            if (obs !== DW'(32'hA0 + i)) begin
                errors++; $display("FAIL drain_vc2 got %h exp %h", obs, 32'hA0 + i);
            end
        end
        checks++;
        if (dut_status() !== m_status()) begin
            errors++; $display("FAIL drain_status got %h exp %h", dut_status(), m_status());
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] obs;
        logic [DW-1:0] exp_q [$];
        for (int i = 0; i < D; i++) cycle(1, 1, DW'(32'hB0 + i), 0, 0, obs);
        cycle(1, 1, 32'hBB, 0, 0, obs);
        checks++;
        if (overflow !== 1'b1 || cnt_unpack(count, 2'd1) !== CW'(D)) begin
            errors++;
            $display("FAIL ovf_reject got ovf=%b cnt=%0d exp ovf=1 cnt=4",
                     overflow, cnt_unpack(count, 2'd1));
        end
        cycle(1, 1, 32'hCC, 1, 1, obs);
        checks++;
        if (obs !== 32'hB0 || cnt_unpack(count, 2'd1) !== CW'(D) || full[1] !== 1'b1) begin
            errors++;
            $display("FAIL full_pushpop got data=%h cnt=%0d exp data=b0 cnt=4",
                     obs, cnt_unpack(count, 2'd1));
        end
        exp_q = '{32'hB1, 32'hB2, 32'hB3, 32'hCC};
        foreach (exp_q[i]) begin
            cycle(0, 0, 0, 1, 1, obs);
            checks++;
            if (obs !== exp_q[i]) begin
                errors++; $display("FAIL ovf_contents got %h exp %h", obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_underflow();
        logic [DW-1:0] obs;
        do_reset();
        cycle(1, 3, 32'h11, 1, 3, obs);
        checks++;
        if (underflow !== 1'b1 || overflow !== 1'b0 || cnt_unpack(count, 2'd3) !== CW'(1)) begin
            errors++;
            $display("FAIL unf_same_vc got unf=%b ovf=%b cnt=%0d exp unf=1 ovf=0 cnt=1",
                     underflow, overflow, cnt_unpack(count, 2'd3));
        end
        cycle(0, 0, 0, 1, 3, obs);
        checks++;
        if (obs !== 32'h11) begin
            errors++; $display("FAIL unf_data got %h exp 11", obs);
        end
    endtask

    task automatic test_cross_vc();
        logic [DW-1:0] obs;
        cycle(1, 1, 32'h71, 0, 0, obs);
        cycle(1, 1, 32'h72, 0, 0, obs);
        cycle(1, 0, 32'h55, 1, 1, obs);
        checks++;
        if (obs !== 32'h71 || cnt_unpack(count, 2'd0) !== CW'(1)
            || cnt_unpack(count, 2'd1) !== CW'(1)) begin
            errors++;
            $display("FAIL cross_vc got data=%h c0=%0d c1=%0d exp data=71 c0=1 c1=1",
                     obs, cnt_unpack(count, 2'd0), cnt_unpack(count, 2'd1));
        end
        checks++;
        if (dut_status() !== m_status()) begin
            errors++; $display("FAIL cross_status got %h exp %h", dut_status(), m_status());
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] obs;
        do_reset();
        cycle(1, 0, 0, 0, 0, obs);
        for (int i = 1; i < 10; i++) begin
            cycle(1, 0, DW'(i), 1, 0, obs);
            checks++;
            if (obs !== DW'(i - 1) || cnt_unpack(count, 2'd0) !== CW'(1)) begin
                errors++;
                $display("FAIL wrap got data=%h cnt=%0d exp data=%h cnt=1",
                         obs, cnt_unpack(count, 2'd0), i - 1);
            end
        end
        cycle(0, 0, 0, 1, 0, obs);
        checks++;
        if (obs !== DW'(9) || {overflow, underflow} !== 2'b00 || empty !== 4'hF) begin
            errors++;
            $display("FAIL wrap_end got data=%h flags=%b e=%h exp data=9 flags=00 e=f",
                     obs, {overflow, underflow}, empty);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] obs, exp_d, d;
        bit pu, po;
        int pvc, ovc;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            pu  = ($urandom_range(0, 99) < 60);
            po  = ($urandom_range(0, 99) < 45);
            pvc = $urandom_range(0, NV - 1);
            ovc = $urandom_range(0, NV - 1);
            if (n % 50 == 0) pvc = ovc;
            d = $urandom;
            exp_d = m_head(ovc);
            cycle(pu, pvc, d, po, ovc, obs);
            checks++;
            if (obs !== exp_d) begin
                errors++; $display("FAIL rand_data n=%0d got %h exp %h", n, obs, exp_d);
            end
            checks++;
            if (dut_status() !== m_status()) begin
                errors++;
                $display("FAIL rand_status n=%0d got %h exp %h", n, dut_status(), m_status());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] obs;
        for (int i = 0; i < 3; i++) cycle(1, 0, DW'(32'hD0 + i), 0, 0, obs);
        rst = 1'b1;
        push = 1'b1; push_vc = '0; push_data = 32'hEE;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push = 1'b0;
        model_reset();
        checks++;
        if (count !== '0 || empty !== 4'hF || full !== '0 || almost_full !== '0
            || {overflow, underflow} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid got cnt=%h e=%h f=%h af=%h flags=%b",
                     count, empty, full, almost_full, {overflow, underflow});
        end
        pop_vc = '0;
        #1;
        checks++;
        if (pop_data !== '0) begin
            errors++; $display("FAIL reset_mid_data got %h exp 0", pop_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (count !== '0) begin
            errors++; $display("FAIL reset_mid_discard got cnt=%h exp 0", count);
        end
    endtask

    initial begin
        rst = 1'b1;
        push = 1'b0; pop = 1'b0;
        push_vc = '0; pop_vc = '0; push_data = '0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_cross_vc();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
